speed_display: RTL
==================

# speed_display

Converts the two car speed magnitudes from the game top level (`o_car1_v_m`, `o_car2_v_m`) into decimal digits and drives the board's active-low seven-segment displays. It samples both speeds once per frame, on the rising edge of the render clock. A single shared sequential double-dabble engine converts both values. Both displays then update in the same cycle, so the two speed readouts always belong to the same frame.

## Interface
- `VEL_WIDTH`, default 10: width of each speed input; equals `game_pkg::VELOCITY_OUTPUT_WIDTH`.
- `DIGITS`, default 3: decimal digits per car; saturation value is 10^DIGITS−1.
- `BLANK_LZ`, default 1: when 1, leading-zero digits are blanked; digit 0 is never blanked.
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_render_clk` in 1: frame tick from the VGA block, synchronous to `i_clk`; a sample is taken on its rising edge.
- `i_car1_v_m` in VEL_WIDTH: car 1 speed, unsigned.
- `i_car2_v_m` in VEL_WIDTH: car 2 speed, unsigned.
- `o_car1_hex` out 7*DIGITS: car 1 segments, digit k at bits [7k+6:7k], bit order a..g = bit0..bit6, active low.
- `o_car2_hex` out 7*DIGITS: car 2 segments, same layout as car 1.
- `o_car1_bcd` out 4*DIGITS: registered BCD of the car 1 value currently displayed.
- `o_car2_bcd` out 4*DIGITS: registered BCD of the car 2 value currently displayed.
- `o_busy` out 1: high while a conversion is in flight.
- `o_update` out 1: one-cycle pulse in the cycle after a new pair of values is committed.

## Operation
- Edge detection:
  - `render_prev` register, reset value 1, so a high `i_render_clk` at reset release is not treated as an edge.
  - edge = `i_render_clk & ~render_prev`.
- Snapshot: on an edge seen in IDLE, each speed is captured saturated, snap = min(v, 10^DIGITS−1). With the defaults, 1023 → 999.
- FSM states:
  - IDLE: on edge, capture both snapshots → START1. An edge seen in any other state is dropped, not queued.
  - START1: assert `conv_start` with car 1 snapshot → WAIT1.
  - WAIT1: on `conv_done`, latch `conv_bcd` into `bcd1_tmp` → START2.
  - START2: assert `conv_start` with car 2 snapshot → WAIT2.
  - WAIT2: on `conv_done`, load `o_car1_bcd` ← `bcd1_tmp` and `o_car2_bcd` ← `conv_bcd` together → IDLE.
- `o_busy` = (state != IDLE). `o_update` is registered and high for the one cycle after the WAIT2 commit.
- Conversion engine:
  - On `start`: load the binary value, clear the BCD accumulator, set count = VEL_WIDTH.
  - Each following cycle performs one double-dabble step: add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - When count reaches 0, `done` is registered high for exactly one cycle with `bcd` valid.
  - BCD accumulator is 4*DIGITS bits wide; saturation guarantees no overflow.
- Segment encoding, combinational from the registered BCD:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Bits are listed g..a.
  - blank = 1111111.
  - With BLANK_LZ, digit k>0 is blanked if it and every higher digit are 0.
- Reset, asynchronous and allowed at any time including mid-conversion:
  - state IDLE; all BCD registers 0; `o_busy`=0; `o_update`=0; engine cleared.
  - Displays then show a single "0" (BLANK_LZ=1) or "000" (BLANK_LZ=0).

## Timing
- Let E be the clock edge at which IDLE detects the render edge.
  - Engine loads car 1 at E+1.
  - Car 1 `done` is seen at E+W+2.
  - Engine loads car 2 at E+W+3.
  - Commit happens at E+2W+4, where W = VEL_WIDTH: 24 cycles for the defaults.
  - `o_update` is high in the cycle following E+2W+4.
  - `o_busy` is high from E+1 through E+2W+4.
- Input changes after E do not affect the in-flight result.
- Outputs are stable between commits. The two cars' BCD and hex outputs never change in different cycles.

## Structure
- `game_pkg` additions:
  - `SPEED_DIGITS` constant.
  - `SEG_BLANK` constant.
  - a `seg7_encode` function (BCD nibble → 7 bits, active low).
  - the FSM state enum.
- Sub-module `bcd_converter`, parameterised by VEL_WIDTH and DIGITS, with the start/done handshake described above. The top instantiates it once.

## Test plan
- Reset, then hold `i_render_clk`=1 at release → no conversion; `o_busy`=0; `o_car1_hex` digit0 = 1000000, digits 1–2 = 1111111.
- v1=123, v2=7, one render edge → `o_update` pulse exactly 25 cycles after E; `o_car1_bcd`=0x123, `o_car2_bcd`=0x007; car 2 digits 1–2 blank.
- v1=1023, v2=999 → both BCD = 0x999 (saturation), all six digits show 0010000.
- Change v1 from 50 to 60 at E+5 → committed `o_car1_bcd`=0x050; the next edge yields 0x060.
- Second render edge at E+10 → dropped; exactly one `o_update`; the next edge after IDLE converts normally.
- Assert `i_rst_n` low at E+15 → immediate IDLE, BCD 0, no `o_update`; the next edge converts correctly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, seven-segment helpers and the
// speed display FSM state type.
package game_pkg;

  localparam int VELOCITY_OUTPUT_WIDTH = 10;
  localparam int SPEED_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START1,
    S_WAIT1,
    S_START2,
    S_WAIT2
  } speed_state_t;

  // Bit order a..g = bit0..bit6, active low.
  function automatic logic [6:0] seg7_encode(
    input logic [3:0] nib
  );
    case (nib)
      4'd0:    seg7_encode = 7'b1000000;
      4'd1:    seg7_encode = 7'b1111001;
      4'd2:    seg7_encode = 7'b0100100;
      4'd3:    seg7_encode = 7'b0110000;
      4'd4:    seg7_encode = 7'b0011001;
      4'd5:    seg7_encode = 7'b0010010;
      4'd6:    seg7_encode = 7'b0000010;
      4'd7:    seg7_encode = 7'b1111000;
      4'd8:    seg7_encode = 7'b0000000;
      4'd9:    seg7_encode = 7'b0010000;
      default: seg7_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: one shift-add step per cycle,
// single-cycle done pulse once all input bits are consumed.
module bcd_converter #(
  parameter int VEL_WIDTH = 10,
  parameter int DIGITS    = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   start,
  input  logic [VEL_WIDTH-1:0]   bin,
  output logic [4*DIGITS-1:0]    bcd,
  output logic                   done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VEL_WIDTH + 1);

  logic [VEL_WIDTH-1:0] bin_q;
  logic [BW-1:0]        bcd_q;
  logic [BW-1:0]        adj;
  logic [CW-1:0]        cnt;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt   <= CW'(VEL_WIDTH);
      done  <= 1'b0;
    end else if (cnt != '0) begin
      bcd_q <= {adj[BW-2:0], bin_q[VEL_WIDTH-1]};
      bin_q <= bin_q << 1;
      cnt   <= cnt - 1'b1;
      done  <= (cnt == CW'(1));
    end else begin
      done  <= 1'b0;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/speed_display.sv
// Per-frame snapshot of both car speeds, converted in turn by
// one shared BCD engine and committed to the displays together.
module speed_display
  import game_pkg::*;
#(
  parameter int VEL_WIDTH = VELOCITY_OUTPUT_WIDTH,
  parameter int DIGITS    = SPEED_DIGITS,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_render_clk,
  input  logic [VEL_WIDTH-1:0]  i_car1_v_m,
  input  logic [VEL_WIDTH-1:0]  i_car2_v_m,
  output logic [7*DIGITS-1:0]   o_car1_hex,
  output logic [7*DIGITS-1:0]   o_car2_hex,
  output logic [4*DIGITS-1:0]   o_car1_bcd,
  output logic [4*DIGITS-1:0]   o_car2_bcd,
  output logic                  o_busy,
  output logic                  o_update
);

  localparam int BW      = 4 * DIGITS;
  localparam int SAT_MAX = (10 ** DIGITS) - 1;

  speed_state_t         state;
  logic                 render_prev;
  logic                 render_edge;
  logic [VEL_WIDTH-1:0] snap1;
  logic [VEL_WIDTH-1:0] snap2;
  logic [BW-1:0]        bcd1_tmp;
  logic                 conv_start;
  logic [VEL_WIDTH-1:0] conv_bin;
  logic [BW-1:0]        conv_bcd;
  logic                 conv_done;

  function automatic logic [VEL_WIDTH-1:0] sat(
    input logic [VEL_WIDTH-1:0] v
  );
    if (32'(v) > SAT_MAX)
      sat = VEL_WIDTH'(SAT_MAX);
    else
      sat = v;
  endfunction

  function automatic logic [7*DIGITS-1:0] to_hex(
    input logic [BW-1:0] b
  );
    logic lead;
    lead   = 1'b1;
    to_hex = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead = lead & (b[4*k +: 4] == 4'd0);
      if (BLANK_LZ && k != 0 && lead)
        to_hex[7*k +: 7] = SEG_BLANK;
      else
        to_hex[7*k +: 7] = seg7_encode(b[4*k +: 4]);
    end
  endfunction

  assign render_edge = i_render_clk & ~render_prev;
  assign conv_start  = (state == S_START1) ||
                       (state == S_START2);
  assign conv_bin    = (state == S_START1) ? snap1 : snap2;
  assign o_busy      = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      render_prev <= 1'b1;
      snap1       <= '0;
      snap2       <= '0;
      bcd1_tmp    <= '0;
      o_car1_bcd  <= '0;
      o_car2_bcd  <= '0;
      o_update    <= 1'b0;
    end else begin
      render_prev <= i_render_clk;
      o_update    <= 1'b0;
      case (state)
        S_IDLE: if (render_edge) begin
          snap1 <= sat(i_car1_v_m);
          snap2 <= sat(i_car2_v_m);
          state <= S_START1;
        end
        S_START1: state <= S_WAIT1;
        S_WAIT1: if (conv_done) begin
          bcd1_tmp <= conv_bcd;
          state    <= S_START2;
        end
        S_START2: state <= S_WAIT2;
        S_WAIT2: if (conv_done) begin
          o_car1_bcd <= bcd1_tmp;
          o_car2_bcd <= conv_bcd;
          o_update   <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  bcd_converter #(
    .VEL_WIDTH (VEL_WIDTH),
    .DIGITS    (DIGITS)
  ) u_conv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (conv_start),
    .bin     (conv_bin),
    .bcd     (conv_bcd),
    .done    (conv_done)
  );

  assign o_car1_hex = to_hex(o_car1_bcd);
  assign o_car2_hex = to_hex(o_car2_bcd);

endmodule
